frame_renderer: RTL and testbench
=================================

FRAME_RENDERER -- requirements
Module: frame_renderer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SCREEN_W, 160, visible columns.
  SCREEN_H, 120, visible rows.
  BIRD_X, 20, fixed left column of the bird.
  BIRD_SIZE, 4, bird square edge in pixels.
  PILLAR_W, 10, pillar width in pixels.
  GAP_H, 30, vertical gap height in each pillar.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state changes on its rising edge.
  clr  in  1  reset; asynchronous, active-high.
  start  in  1  frame request pulse.
  game_over  in  1  game ended; selects the end-of-game background.
  bird_y  in  10  bird top row.
  pillar1_x, pillar2_x, pillar3_x  in  10 each  pillar left column.
  pillar1_y, pillar2_y, pillar3_y  in  10 each  gap top row.
  vga_x  out  8  pixel column to the VGA adapter.
  vga_y  out  7  pixel row to the VGA adapter.
  colour  out  3  pixel colour, RGB one bit each.
  plot  out  1  pixel write strobe.
  busy  out  1  frame in progress.
  done  out  1  one-cycle pulse at frame end.

Function
REQ-003 The block SHALL be the consumer of the game-state coordinate bus: it reads bird and pillar positions and writes every screen pixel to the VGA adapter.
REQ-004 States SHALL be IDLE, SCAN and FINISH.
REQ-005 In IDLE, start=1 at edge N SHALL do all of the following at that edge:
  - latch game_over, bird_y and all six pillar coordinates into snapshot registers;
  - set busy=1;
  - enter SCAN.
REQ-006 Each SCAN cycle SHALL output exactly one pixel with plot=1, in raster order: x increments fastest, 0..SCREEN_W-1, then y increments, 0..SCREEN_H-1.
REQ-007 Pixel k, where k = y*SCREEN_W + x, SHALL appear registered on vga_x, vga_y, colour and plot after edge N+1+k.
REQ-008 After the last pixel (159,119), at edge N+19200, the next edge SHALL:
  - enter FINISH with plot=0, done=1 and busy=0;
  - return to IDLE at the following edge, done=0.
REQ-009 Colour priority SHALL be bird, then pillar, then background.
REQ-010 Colours SHALL be bird 3'b110, pillar 3'b010, background 3'b011; background SHALL be 3'b100 when the snapshot game_over=1.
REQ-011 A pixel SHALL be bird when both hold: BIRD_X <= x < BIRD_X+BIRD_SIZE and bird_y <= y < bird_y+BIRD_SIZE.
REQ-012 A pixel SHALL be pillar i when both hold: pillari_x <= x < pillari_x+PILLAR_W, and NOT (pillari_y <= y < pillari_y+GAP_H).
REQ-013 All range comparisons SHALL use 11-bit zero-extended sums, so that no wrap occurs.
REQ-014 Objects SHALL be clipped at the screen edge:
  - a pillar with x >= 160 is invisible;
  - a pillar with x = 155 draws only columns 155..159;
  - a bird with bird_y >= 120 is invisible.
REQ-015 start while busy=1 SHALL be ignored, with no restart and no snapshot update.
REQ-016 Input changes during SCAN SHALL NOT affect the frame in progress.
REQ-017 When in IDLE or FINISH, plot SHALL be 0, and vga_x, vga_y and colour SHALL hold their last values.

Reset
REQ-018 clr=1 SHALL asynchronously force: state IDLE, pixel counters 0, snapshot registers 0, vga_x=0, vga_y=0, colour=0, plot=0, busy=0, done=0.
REQ-019 clr asserted mid-frame SHALL abort the frame with no done pulse.
REQ-020 The first frame after clr deasserts SHALL require a new start.

Structure
REQ-021 Colour codes, screen dimensions and object-size defaults SHALL live in a shared package, game_pkg, used by all game blocks.
REQ-022 Per-pixel classification SHALL be one combinational sub-module, pixel_colour, taking (x, y, snapshot) and returning colour.
REQ-023 frame_renderer SHALL contain only the FSM, the counters and the output registers.

Verification
REQ-024 Reset: clr=1 mid-SCAN -> next sample shows plot=0, busy=0, done=0, vga_x=0, vga_y=0; no done pulse follows.
REQ-025 Timing: start at edge N with no objects on screen (all x=200, bird_y=200) -> 19200 plots, all colour 3'b011, first plot (0,0) after N+1, done=1 after N+19201 only.
REQ-026 Shapes: bird_y=50, pillar1_x=40, pillar1_y=60:
  - (20,50) and (23,53) are 3'b110; (24,50) is 3'b011;
  - (45,10) is 3'b010; (45,70) is 3'b011; (45,90) is 3'b010.
REQ-027 Clip: pillar2_x=155 -> columns 155..159 are 3'b010 outside the gap; no wrap to column 0..4.
REQ-028 Snapshot: game_over=1 at start, pillar1_x changed mid-frame, second start mid-frame -> background 3'b100, pillar drawn at the original x, exactly one done pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, colour codes and the frame snapshot bundle.
// Used by every block that reads or draws the game state.
package game_pkg;

    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_SCREEN_H  = 120;
    localparam int DEF_BIRD_X    = 20;
    localparam int DEF_BIRD_SIZE = 4;
    localparam int DEF_PILLAR_W  = 10;
    localparam int DEF_GAP_H     = 30;
    localparam int N_PILLARS     = 3;

    localparam logic [2:0] C_BIRD    = 3'b110;
    localparam logic [2:0] C_PILLAR  = 3'b010;
    localparam logic [2:0] C_BG      = 3'b011;
    localparam logic [2:0] C_BG_OVER = 3'b100;

    typedef struct packed {
        logic                          game_over;
        logic [9:0]                    bird_y;
        logic [N_PILLARS-1:0][9:0]     pillar_x;
        logic [N_PILLARS-1:0][9:0]     pillar_y;
    } snap_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

endpackage

// File: rtl/pixel_colour.sv
// Combinational classification of one screen pixel against the
// frame snapshot: bird over pillar over background.
module pixel_colour
    import game_pkg::*;
#(
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int PILLAR_W  = DEF_PILLAR_W,
    parameter int GAP_H     = DEF_GAP_H
) (
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  snap_t      snap,
    output logic [2:0] colour
);

    localparam logic [10:0] BX = 11'(BIRD_X);
    localparam logic [10:0] BS = 11'(BIRD_SIZE);
    localparam logic [10:0] PW = 11'(PILLAR_W);
    localparam logic [10:0] GH = 11'(GAP_H);

    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] by11;
    logic [10:0] px_lo;
    logic [10:0] gy_lo;
    logic        bird_hit;
    logic        pillar_hit;

    // 11-bit sums keep objects near the right/bottom edge from wrapping
    assign x11  = {3'b000, x};
    assign y11  = {4'b0000, y};
    assign by11 = {1'b0, snap.bird_y};

    assign bird_hit = (x11 >= BX) && (x11 < BX + BS)
                   && (y11 >= by11) && (y11 < by11 + BS);

    always_comb begin
        pillar_hit = 1'b0;
        px_lo      = '0;
        gy_lo      = '0;
        for (int i = 0; i < N_PILLARS; i++) begin
            px_lo = {1'b0, snap.pillar_x[i]};
            gy_lo = {1'b0, snap.pillar_y[i]};
            if ((x11 >= px_lo) && (x11 < px_lo + PW)
                && !((y11 >= gy_lo) && (y11 < gy_lo + GH)))
                pillar_hit = 1'b1;
        end
    end

    always_comb begin
        if (bird_hit)
            colour = C_BIRD;
        else if (pillar_hit)
            colour = C_PILLAR;
        else if (snap.game_over)
            colour = C_BG_OVER;
        else
            colour = C_BG;
    end

endmodule

// File: rtl/frame_renderer.sv
// Raster-scans one full frame per start request, drawing a frozen
// snapshot of the game state into the VGA adapter one pixel a cycle.
module frame_renderer
    import game_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int PILLAR_W  = DEF_PILLAR_W,
    parameter int GAP_H     = DEF_GAP_H
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       game_over,
    input  logic [9:0] bird_y,
    input  logic [9:0] pillar1_x,
    input  logic [9:0] pillar2_x,
    input  logic [9:0] pillar3_x,
    input  logic [9:0] pillar1_y,
    input  logic [9:0] pillar2_y,
    input  logic [9:0] pillar3_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

    state_t     state, state_d;
    logic [7:0] cx, cx_d;
    logic [6:0] cy, cy_d;
    snap_t      snap, snap_d, snap_in;
    logic [7:0] vx_d;
    logic [6:0] vy_d;
    logic [2:0] col_d, pix_col;
    logic       plot_d, busy_d, done_d;
    logic       last_px;

    assign snap_in = {game_over, bird_y,
                      pillar3_x, pillar2_x, pillar1_x,
                      pillar3_y, pillar2_y, pillar1_y};

    assign last_px = (cx == X_MAX) && (cy == Y_MAX);

    pixel_colour #(
        .BIRD_X    (BIRD_X),
        .BIRD_SIZE (BIRD_SIZE),
        .PILLAR_W  (PILLAR_W),
        .GAP_H     (GAP_H)
    ) u_pix (
        .x      (cx),
        .y      (cy),
        .snap   (snap),
        .colour (pix_col)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_d;
    end

    // done lands one edge after the last pixel, while FINISH drains
    always_comb begin
        state_d = state;
        cx_d    = cx;
        cy_d    = cy;
        snap_d  = snap;
        vx_d    = vga_x;
        vy_d    = vga_y;
        col_d   = colour;
        plot_d  = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    snap_d  = snap_in;
                    busy_d  = 1'b1;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                plot_d = 1'b1;
                vx_d   = cx;
                vy_d   = cy;
                col_d  = pix_col;
                if (last_px) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = FINISH;
                end else if (cx == X_MAX) begin
                    cx_d = '0;
                    cy_d = cy + 7'd1;
                end else begin
                    cx_d = cx + 8'd1;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cx     <= '0;
            cy     <= '0;
            snap   <= '0;
            vga_x  <= '0;
            vga_y  <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cx     <= cx_d;
            cy     <= cy_d;
            snap   <= snap_d;
            vga_x  <= vx_d;
            vga_y  <= vy_d;
            colour <= col_d;
            plot   <= plot_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer: expected frames are queued at
// start and compared against every plotted pixel.
module tb_frame_renderer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       game_over;
    logic [9:0] bird_y;
    logic [9:0] pillar1_x, pillar2_x, pillar3_x;
    logic [9:0] pillar1_y, pillar2_y, pillar3_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot, busy, done;

    frame_renderer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .game_over (game_over),
        .bird_y    (bird_y),
        .pillar1_x (pillar1_x),
        .pillar2_x (pillar2_x),
        .pillar3_x (pillar3_x),
        .pillar1_y (pillar1_y),
        .pillar2_y (pillar2_y),
        .pillar3_y (pillar3_y),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [2:0]  fm [0:159][0:119];

    int plots, dones, first_c, last_c, done_c;
    logic busy0, busy_end, plot_end;
    logic [7:0] x_end;
    logic [6:0] y_end;
    logic [17:0] got_px, want_px;

    function automatic logic [2:0] model(int x, int y);
        int px[3];
        int py[3];
        int by;
        px = '{int'(pillar1_x), int'(pillar2_x), int'(pillar3_x)};
        py = '{int'(pillar1_y), int'(pillar2_y), int'(pillar3_y)};
        by = int'(bird_y);
        if (x >= 20 && x < 24 && y >= by && y < by + 4)
            return 3'b110;
        for (int i = 0; i < 3; i++)
            if (x >= px[i] && x < px[i] + 10 && !(y >= py[i] && y < py[i] + 30))
                return 3'b010;
        return game_over ? 3'b100 : 3'b011;
    endfunction

    task automatic set_inputs(int by, int p1x, int p1y, int p2x, int p2y,
                              int p3x, int p3y, logic go);
        bird_y    = 10'(by);
        pillar1_x = 10'(p1x);
        pillar1_y = 10'(p1y);
        pillar2_x = 10'(p2x);
        pillar2_y = 10'(p2y);
        pillar3_x = 10'(p3x);
        pillar3_y = 10'(p3y);
        game_over = go;
    endtask

    task automatic start_frame();
        exp_q.delete();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back({8'(x), 7'(y), model(x, y)});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
    endtask

    // poke > 0: at that cycle change inputs and request another frame
    task automatic capture(int poke);
        obs_q.delete();
        plots   = 0;
        dones   = 0;
        first_c = -1;
        last_c  = -1;
        done_c  = -1;
        for (int c = 1; c <= 19205; c++) begin
            @(negedge clk);
            if (plot) begin
                obs_q.push_back({vga_x, vga_y, colour});
                if (vga_x < 160 && vga_y < 120)
                    fm[vga_x][vga_y] = colour;
                plots++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
            if (c == 19201) begin
                busy_end = busy;
                plot_end = plot;
                x_end    = vga_x;
                y_end    = vga_y;
            end
            if (c == poke) begin
                pillar1_x = 10'd90;
                game_over = 1'b0;
                bird_y    = 10'd10;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    function automatic int first_diff();
        int idx = 0;
        int bad = -1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            want_px = exp_q.pop_front();
            got_px  = obs_q.pop_front();
            if (bad < 0 && got_px !== want_px) bad = idx;
            idx++;
        end
        if (bad < 0 && (exp_q.size() != 0 || obs_q.size() != 0)) bad = idx;
        return bad;
    endfunction

    task automatic test_reset();
        clr   = 1'b1;
        start = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({vga_x, vga_y, colour, plot, busy, done} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%b p=%b b=%b d=%b want all 0",
                     vga_x, vga_y, colour, plot, busy, done);
        end
        clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_autostart: got plot=%b busy=%b want 0 0", plot, busy);
        end
    endtask

    task automatic test_timing();
        int bad, non_bg;
        set_inputs(200, 200, 0, 200, 0, 200, 0, 1'b0);
        start_frame();
        capture(0);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL timing_busy_set: got %b want 1", busy0);
        end
        n_cmp++;
        if (first_c != 1 || obs_q[0][17:3] !== 15'd0) begin
            n_bad++;
            $display("FAIL timing_first_plot: got cycle %0d xy=%h want 1 xy=0",
                     first_c, obs_q[0][17:3]);
        end
        non_bg = 0;
        foreach (obs_q[i]) if (obs_q[i][2:0] !== 3'b011) non_bg++;
        n_cmp++;
        if (plots != 19200 || last_c != 19200 || non_bg != 0) begin
            n_bad++;
            $display("FAIL timing_plots: got %0d last %0d nonbg %0d want 19200 19200 0",
                     plots, last_c, non_bg);
        end
        n_cmp++;
        if (dones != 1 || done_c != 19201) begin
            n_bad++;
            $display("FAIL timing_done: got %0d pulses at %0d want 1 at 19201", dones, done_c);
        end
        n_cmp++;
        if (busy_end !== 1'b0 || plot_end !== 1'b0 || x_end !== 8'd159 || y_end !== 7'd119) begin
            n_bad++;
            $display("FAIL timing_end_hold: got b=%b p=%b x=%0d y=%0d want 0 0 159 119",
                     busy_end, plot_end, x_end, y_end);
        end
        bad = first_diff();
        n_cmp++;
        if (bad != -1) begin
            n_bad++;
            $display("FAIL timing_frame: pixel %0d got %h want %h", bad, got_px, want_px);
        end
    endtask

    task automatic test_shapes();
        int bad;
        logic [2:0] got[6];
        logic [2:0] want[6];
        set_inputs(50, 40, 60, 155, 20, 200, 0, 1'b0);
        start_frame();
        capture(0);
        bad = first_diff();
        n_cmp++;
        if (bad != -1) begin
            n_bad++;
            $display("FAIL shapes_frame: pixel %0d got %h want %h", bad, got_px, want_px);
        end
        got  = '{fm[20][50], fm[23][53], fm[24][50], fm[45][10], fm[45][70], fm[45][90]};
        want = '{3'b110, 3'b110, 3'b011, 3'b010, 3'b011, 3'b010};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL shapes_point%0d: got %b want %b", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_clip();
        for (int x = 155; x < 160; x++) begin
            n_cmp++;
            if (fm[x][10] !== 3'b010 || fm[x][30] !== 3'b011) begin
                n_bad++;
                $display("FAIL clip_col%0d: got %b/%b want 010/011", x, fm[x][10], fm[x][30]);
            end
        end
        for (int x = 0; x < 5; x++) begin
            n_cmp++;
            if (fm[x][10] !== 3'b011) begin
                n_bad++;
                $display("FAIL clip_wrap%0d: got %b want 011", x, fm[x][10]);
            end
        end
        n_cmp++;
        if (fm[154][10] !== 3'b011) begin
            n_bad++;
            $display("FAIL clip_left: got %b want 011", fm[154][10]);
        end
    endtask

    task automatic test_snapshot();
        int bad;
        set_inputs(200, 40, 60, 200, 0, 200, 0, 1'b1);
        start_frame();
        capture(5000);
        bad = first_diff();
        n_cmp++;
        if (bad != -1) begin
            n_bad++;
            $display("FAIL snap_frame: pixel %0d got %h want %h", bad, got_px, want_px);
        end
        n_cmp++;
        if (fm[0][0] !== 3'b100 || fm[45][10] !== 3'b010 || fm[95][10] !== 3'b100) begin
            n_bad++;
            $display("FAIL snap_points: got %b %b %b want 100 010 100",
                     fm[0][0], fm[45][10], fm[95][10]);
        end
        n_cmp++;
        if (dones != 1 || done_c != 19201 || plots != 19200) begin
            n_bad++;
            $display("FAIL snap_single_frame: got %0d done at %0d, %0d plots want 1 19201 19200",
                     dones, done_c, plots);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done, seen_act;
        set_inputs(200, 200, 0, 200, 0, 200, 0, 1'b0);
        start_frame();
        repeat (100) @(negedge clk);
        clr = 1'b1;
        #1;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || vga_x !== 8'd0 || vga_y !== 7'd0) begin
            n_bad++;
            $display("FAIL midreset_state: got p=%b b=%b d=%b x=%0d y=%0d want 0",
                     plot, busy, done, vga_x, vga_y);
        end
        @(negedge clk);
        clr = 1'b0;
        seen_done = 0;
        seen_act  = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (plot || busy) seen_act++;
        end
        n_cmp++;
        if (seen_done != 0 || seen_act != 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d done, %0d active want 0 0",
                     seen_done, seen_act);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_shapes();
        test_clip();
        test_snapshot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
